// File: rtl/tcdm_rx_if_ipa_pkg.sv
// Shared types and constants for the mini DMA channel TCDM write initiator.
package mchan_ipa_pkg;

  typedef enum logic [1:0] {
    RX_RUN,
    RX_DRAIN,
    RX_DONE
  } rx_if_state_e;

  localparam logic [3:0] TCDM_BE_FULL = 4'b1111;

endpackage

// File: rtl/tcdm_rx_if_ipa_if.sv
// Beat, RX data and TCDM bus signals of the write initiator.
// slave = the initiator's view, master = the environment's view.
interface tcdm_rx_if_ipa_if #(
  parameter int unsigned TRANS_SID_WIDTH = 2,
  parameter int unsigned TCDM_ADD_WIDTH  = 12
);

  logic                       beat_eop_i;
  logic [TRANS_SID_WIDTH-1:0] beat_sid_i;
  logic [TCDM_ADD_WIDTH-1:0]  beat_add_i;
  logic [3:0]                 beat_be_i;
  logic                       beat_we_ni;
  logic                       beat_req_i;
  logic                       beat_gnt_o;

  logic [31:0]                rx_data_dat_i;
  logic                       rx_data_req_i;
  logic                       rx_data_gnt_o;

  logic                       tcdm_req_o;
  logic [31:0]                tcdm_add_o;
  logic                       tcdm_we_o;
  logic [31:0]                tcdm_wdata_o;
  logic [3:0]                 tcdm_be_o;
  logic                       tcdm_gnt_i;
  logic [31:0]                tcdm_r_rdata_i;
  logic                       tcdm_r_valid_i;

  modport slave (
    input  beat_eop_i, beat_sid_i, beat_add_i, beat_be_i, beat_we_ni, beat_req_i,
    output beat_gnt_o,
    input  rx_data_dat_i, rx_data_req_i,
    output rx_data_gnt_o,
    output tcdm_req_o, tcdm_add_o, tcdm_we_o, tcdm_wdata_o, tcdm_be_o,
    input  tcdm_gnt_i, tcdm_r_rdata_i, tcdm_r_valid_i
  );

  modport master (
    output beat_eop_i, beat_sid_i, beat_add_i, beat_be_i, beat_we_ni, beat_req_i,
    input  beat_gnt_o,
    output rx_data_dat_i, rx_data_req_i,
    input  rx_data_gnt_o,
    input  tcdm_req_o, tcdm_add_o, tcdm_we_o, tcdm_wdata_o, tcdm_be_o,
    output tcdm_gnt_i, tcdm_r_rdata_i, tcdm_r_valid_i
  );

endinterface

// File: rtl/tcdm_rx_if_ipa_fifo.sv
// Small circular FIFO; head is visible combinationally on data_o.
// Occupancy is tracked by the owner, which never pushes when full
// unless it pops in the same cycle.
module mchan_fifo_ipa #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned DATA_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned PTR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DATA_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= data_i;
  end

  // Read/write pointer advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  assign data_o = r_mem[r_rd_ptr];

endmodule

// File: rtl/tcdm_rx_if_ipa.sv
// Write-side TCDM initiator: pairs write beats with RX data words, issues
// TCDM writes, tracks outstanding acks and pulses synch on eop acks.
module tcdm_rx_if_ipa
  import mchan_ipa_pkg::*;
#(
  parameter int unsigned TRANS_SID_WIDTH = 2,
  parameter int unsigned TCDM_ADD_WIDTH  = 12,
  parameter int unsigned OUTSTANDING     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  tcdm_rx_if_ipa_if.slave            bus,
  output logic                       synch_req_o,
  output logic [TRANS_SID_WIDTH-1:0] synch_sid_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       err_o
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned QW    = TRANS_SID_WIDTH + 1;

  rx_if_state_e     r_state;
  rx_if_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;
  logic             w_ack;
  logic             w_issue;
  logic             w_push;
  logic [QW-1:0]    w_head;
  logic             w_unused;

  // An ack in the same cycle frees a slot, so a full queue can still accept.
  assign w_ack   = bus.tcdm_r_valid_i & (r_cnt != '0);
  assign w_issue = (r_state == RX_RUN) & ~flush_i & bus.beat_req_i & ~bus.beat_we_ni
                 & bus.rx_data_req_i & ((r_cnt < CNT_W'(OUTSTANDING)) | w_ack);
  assign w_push  = w_issue & bus.tcdm_gnt_i;

  mchan_fifo_ipa #(
    .DATA_WIDTH (QW),
    .DATA_DEPTH (OUTSTANDING)
  ) i_sid_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_push),
    .data_i ({bus.beat_sid_i, bus.beat_eop_i}),
    .pop_i  (w_ack),
    .data_o (w_head)
  );

  // Outstanding count: net of this cycle's push and pop.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_ack)      w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (!w_push && w_ack) w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  // Flush FSM next state; DRAIN looks at the post-pop count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_RUN:   if (flush_i) w_state_nxt = RX_DRAIN;
      RX_DRAIN: begin
        if (!flush_i)              w_state_nxt = RX_RUN;
        else if (w_cnt_nxt == '0)  w_state_nxt = RX_DONE;
      end
      RX_DONE:  if (!flush_i) w_state_nxt = RX_RUN;
      default:  w_state_nxt = RX_RUN;
    endcase
  end

  // State, count and sticky error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RX_RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (bus.tcdm_r_valid_i && (r_cnt == '0)) r_err <= 1'b1;
    end
  end

  assign synch_req_o  = w_ack & w_head[0];
  assign synch_sid_o  = synch_req_o ? w_head[QW-1:1] : '0;
  assign flush_done_o = (r_state == RX_DONE);
  assign err_o        = r_err;

  assign bus.tcdm_req_o    = w_issue;
  assign bus.beat_gnt_o    = w_push;
  assign bus.rx_data_gnt_o = w_push;
  assign bus.tcdm_add_o    = 32'(bus.beat_add_i);
  assign bus.tcdm_we_o     = bus.beat_we_ni;
  assign bus.tcdm_wdata_o  = bus.rx_data_dat_i;
  assign bus.tcdm_be_o     = bus.beat_be_i;

  // Write acks carry no data.
  assign w_unused = ^bus.tcdm_r_rdata_i;

endmodule

// File: tb/tb_tcdm_rx_if_ipa.sv
module tb_tcdm_rx_if_ipa;
  import mchan_ipa_pkg::*;

  localparam int unsigned SW  = 2;
  localparam int unsigned AW  = 12;
  localparam int unsigned OUT = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          synch_req_o;
  logic [SW-1:0] synch_sid_o;
  logic          flush_done_o;
  logic          err_o;

  int n_pass  = 0;
  int n_total = 0;

  tcdm_rx_if_ipa_if #(.TRANS_SID_WIDTH(SW), .TCDM_ADD_WIDTH(AW)) bus ();

  tcdm_rx_if_ipa #(
    .TRANS_SID_WIDTH (SW),
    .TCDM_ADD_WIDTH  (AW),
    .OUTSTANDING     (OUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .synch_req_o  (synch_req_o),
    .synch_sid_o  (synch_sid_o),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    bus.beat_eop_i     = 1'b0;
    bus.beat_sid_i     = '0;
    bus.beat_add_i     = '0;
    bus.beat_be_i      = '0;
    bus.beat_we_ni     = 1'b0;
    bus.beat_req_i     = 1'b0;
    bus.rx_data_dat_i  = '0;
    bus.rx_data_req_i  = 1'b0;
    bus.tcdm_gnt_i     = 1'b0;
    bus.tcdm_r_rdata_i = '0;
    bus.tcdm_r_valid_i = 1'b0;
    flush_i            = 1'b0;
  endtask

  task automatic beat(input logic [SW-1:0] sid, input logic eop, input logic [AW-1:0] add,
                      input logic [31:0] dat);
    bus.beat_sid_i    = sid;
    bus.beat_eop_i    = eop;
    bus.beat_add_i    = add;
    bus.beat_be_i     = TCDM_BE_FULL;
    bus.beat_we_ni    = 1'b0;
    bus.beat_req_i    = 1'b1;
    bus.rx_data_dat_i = dat;
    bus.rx_data_req_i = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    n_total++;
    if ({bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o, synch_req_o, synch_sid_o,
         flush_done_o, err_o} !== '0)
      $display("FAIL reset_outputs: got %b want all 0", {bus.tcdm_req_o, bus.beat_gnt_o,
               bus.rx_data_gnt_o, synch_req_o, synch_sid_o, flush_done_o, err_o});
    else n_pass++;
    rst_i = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk_i);
    idle();
    beat(2'd1, 1'b1, 12'h040, 32'hCAFE0001);
    bus.tcdm_gnt_i = 1'b1;
    #1;
    n_total++;
    if ({bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o, bus.tcdm_we_o} !== 4'b1110)
      $display("FAIL single_issue: got %b want 1110",
               {bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o, bus.tcdm_we_o});
    else n_pass++;
    n_total++;
    if ({bus.tcdm_add_o, bus.tcdm_wdata_o, bus.tcdm_be_o} !== {32'h40, 32'hCAFE0001, 4'hF})
      $display("FAIL single_payload: got add=%h wdata=%h be=%h want 00000040 cafe0001 f",
               bus.tcdm_add_o, bus.tcdm_wdata_o, bus.tcdm_be_o);
    else n_pass++;
    @(negedge clk_i);
    idle();
    bus.tcdm_r_valid_i = 1'b1;
    #1;
    n_total++;
    if ({synch_req_o, synch_sid_o, err_o} !== {1'b1, 2'd1, 1'b0})
      $display("FAIL single_synch: got req=%b sid=%0d err=%b want 1 1 0",
               synch_req_o, synch_sid_o, err_o);
    else n_pass++;
    @(negedge clk_i);
    idle();
    #1;
    n_total++;
    if ({synch_req_o, synch_sid_o} !== '0)
      $display("FAIL single_synch_pulse: got req=%b sid=%0d want 0 0", synch_req_o, synch_sid_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] sids [3];
    sids[0] = 2'd0; sids[1] = 2'd1; sids[2] = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      idle();
      beat(sids[(i < 2) ? i : 2], (i >= 2), 12'(16 * i), 32'(i));
      bus.tcdm_gnt_i     = 1'b1;
      bus.tcdm_r_valid_i = (i == 4);
      #1;
      n_total++;
      if ({bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o} !== ((i == 2 || i == 3) ? 3'b000 : 3'b111))
        $display("FAIL b2b_issue_%0d: got %b want %b", i,
                 {bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o},
                 (i == 2 || i == 3) ? 3'b000 : 3'b111);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      idle();
      bus.tcdm_r_valid_i = 1'b1;
      #1;
      n_total++;
      if ({synch_req_o, synch_sid_o} !== ((i == 1) ? {1'b1, 2'd2} : 3'b000))
        $display("FAIL b2b_ack_%0d: got req=%b sid=%0d want %b", i, synch_req_o, synch_sid_o,
                 (i == 1) ? {1'b1, 2'd2} : 3'b000);
      else n_pass++;
    end
  endtask

  task automatic test_data_wait();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      idle();
      beat(2'd3, 1'b0, 12'hABC, 32'h12345678);
      bus.rx_data_req_i = (i == 4);
      bus.tcdm_gnt_i    = 1'b1;
      #1;
      n_total++;
      if ({bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o} !== ((i == 4) ? 3'b111 : 3'b000))
        $display("FAIL data_wait_%0d: got %b want %b", i,
                 {bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o}, (i == 4) ? 3'b111 : 3'b000);
      else n_pass++;
    end
    @(negedge clk_i);
    idle();
    bus.tcdm_r_valid_i = 1'b1;
    #1;
    n_total++;
    if (synch_req_o !== 1'b0)
      $display("FAIL data_wait_noeop: got synch=%b want 0", synch_req_o);
    else n_pass++;
  endtask

  task automatic test_read_beat();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      idle();
      beat(2'd1, 1'b1, 12'h100, 32'hDEADBEEF);
      bus.beat_we_ni = 1'b1;
      bus.tcdm_gnt_i = 1'b1;
      #1;
      n_total++;
      if ({bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o} !== 3'b000)
        $display("FAIL read_beat_%0d: got %b want 000", i,
                 {bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o});
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    // Expected {tcdm_req, synch_req, synch_sid, flush_done} for each step.
    logic [4:0] exp [9];
    exp[0] = 5'b1_0_00_0; exp[1] = 5'b1_0_00_0; exp[2] = 5'b0_0_00_0;
    exp[3] = 5'b0_0_00_0; exp[4] = 5'b0_1_11_0; exp[5] = 5'b0_0_00_1;
    exp[6] = 5'b0_0_00_1; exp[7] = 5'b1_0_00_0; exp[8] = 5'b0_1_10_0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      idle();
      if (i != 8) beat((i == 7) ? 2'd2 : 2'd3, (i != 0), 12'h200, 32'(i));
      bus.tcdm_gnt_i     = 1'b1;
      flush_i            = (i >= 2 && i <= 5);
      bus.tcdm_r_valid_i = (i == 3 || i == 4 || i == 8);
      #1;
      n_total++;
      if ({bus.tcdm_req_o, synch_req_o, synch_sid_o, flush_done_o} !== exp[i])
        $display("FAIL flush_step_%0d: got %b want %b", i,
                 {bus.tcdm_req_o, synch_req_o, synch_sid_o, flush_done_o}, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_err_and_reset();
    @(negedge clk_i);
    idle();
    bus.tcdm_r_valid_i = 1'b1;
    #1;
    n_total++;
    if ({synch_req_o, synch_sid_o} !== 3'b000)
      $display("FAIL err_nosynch: got req=%b sid=%0d want 0 0", synch_req_o, synch_sid_o);
    else n_pass++;
    repeat (3) begin
      @(negedge clk_i);
      idle();
      #1;
      n_total++;
      if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o);
      else n_pass++;
    end
    @(negedge clk_i);
    beat(2'd2, 1'b1, 12'h300, 32'h0);
    bus.tcdm_gnt_i = 1'b1;
    @(negedge clk_i);
    idle();
    #2 rst_i = 1'b1;
    #1;
    n_total++;
    if ({bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o, synch_req_o, synch_sid_o,
         flush_done_o, err_o} !== '0)
      $display("FAIL midreset_outputs: got %b want all 0", {bus.tcdm_req_o, bus.beat_gnt_o,
               bus.rx_data_gnt_o, synch_req_o, synch_sid_o, flush_done_o, err_o});
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    bus.tcdm_r_valid_i = 1'b1;
    #1;
    n_total++;
    if (synch_req_o !== 1'b0)
      $display("FAIL midreset_dropped: got synch=%b want 0", synch_req_o);
    else n_pass++;
    @(negedge clk_i);
    idle();
    #1;
    n_total++;
    if (err_o !== 1'b1)
      $display("FAIL midreset_empty_err: got %b want 1", err_o);
    else n_pass++;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_random();
    logic [SW:0] q [$];
    logic        ack;
    logic        issue;
    logic [SW:0] head;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      idle();
      bus.beat_req_i     = ($urandom_range(0, 9) < 7);
      bus.beat_we_ni     = ($urandom_range(0, 9) < 2);
      bus.beat_eop_i     = 1'($urandom);
      bus.beat_sid_i     = SW'($urandom);
      bus.beat_add_i     = AW'($urandom);
      bus.beat_be_i      = 4'($urandom);
      bus.rx_data_dat_i  = $urandom;
      bus.rx_data_req_i  = ($urandom_range(0, 9) < 7);
      bus.tcdm_gnt_i     = ($urandom_range(0, 9) < 6);
      bus.tcdm_r_valid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      ack   = bus.tcdm_r_valid_i;
      issue = bus.beat_req_i && !bus.beat_we_ni && bus.rx_data_req_i
              && ((q.size() < OUT) || ack);
      head  = (q.size() > 0) ? q[0] : '0;
      #1;
      n_total++;
      if ({bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o}
          !== {issue, issue && bus.tcdm_gnt_i, issue && bus.tcdm_gnt_i})
        $display("FAIL rand_issue_c%0d: got %b want %b", c,
                 {bus.tcdm_req_o, bus.beat_gnt_o, bus.rx_data_gnt_o},
                 {issue, issue && bus.tcdm_gnt_i, issue && bus.tcdm_gnt_i});
      else n_pass++;
      n_total++;
      if ({synch_req_o, synch_sid_o} !== ((ack && head[0]) ? {1'b1, head[SW:1]} : 3'b000))
        $display("FAIL rand_synch_c%0d: got req=%b sid=%0d want %b", c, synch_req_o,
                 synch_sid_o, (ack && head[0]) ? {1'b1, head[SW:1]} : 3'b000);
      else n_pass++;
      n_total++;
      if ({bus.tcdm_add_o, bus.tcdm_wdata_o, bus.tcdm_be_o, bus.tcdm_we_o, err_o}
          !== {20'h0, bus.beat_add_i, bus.rx_data_dat_i, bus.beat_be_i, bus.beat_we_ni, 1'b0})
        $display("FAIL rand_payload_c%0d: got add=%h wdata=%h be=%h we=%b err=%b", c,
                 bus.tcdm_add_o, bus.tcdm_wdata_o, bus.tcdm_be_o, bus.tcdm_we_o, err_o);
      else n_pass++;
      if (ack) void'(q.pop_front());
      if (issue && bus.tcdm_gnt_i) q.push_back({bus.beat_sid_i, bus.beat_eop_i});
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_data_wait();
    test_read_beat();
    test_flush();
    test_err_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
